window_mac_engine: RTL and testbench

//  Consumes one 3x3x3 window (27 x 16-bit signed Q8.8 samples) from the image window stage.

---
 rtl/window_mac_engine.sv | 189 ++++++++++++++++++
 tb/tb_window_mac_engine.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_mac_engine.sv
// window_mac_engine: 27-tap Q8.8 window dot product + bias, rescale, saturate.
// Optional build macro RELU_EN clamps negative results to zero.
module window_mac_engine #(
  parameter int LANES = 9,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [431:0] win_data,
  input  logic         win_valid,
  output logic         win_ready,
  input  logic         wt_we,
  input  logic [4:0]   wt_addr,
  input  logic [15:0]  wt_data,
  output logic [15:0]  res_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         busy,
  output logic         wt_err,
  output logic [15:0]  res_count
);

  localparam int NPASS = 27 / LANES;
  localparam int PW    = $clog2(NPASS + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } state_t;

  state_t                    state_q, state_d;
  logic [431:0]              win_q, win_d;
  logic [15:0]               w_q [27];
  logic [15:0]               w_d [27];
  logic [15:0]               bias_q, bias_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [PW-1:0]             pass_q, pass_d;
  logic [15:0]               res_data_q, res_data_d;
  logic                      res_valid_q, res_valid_d;
  logic                      wt_err_q, wt_err_d;
  logic [15:0]               res_count_q, res_count_d;

  logic [PW-1:0]             pidx;
  logic signed [31:0]        prod;
  logic signed [ACC_W-1:0]   lane_sum;
  logic signed [ACC_W:0]     tot;
  logic signed [ACC_W:0]     shr;
  logic [ACC_W-15:0]         hi;
  logic [15:0]               sat;
  logic                      accept;
  int                        idx;

  // Sum of this pass's LANES products; index clamped on the final cycle
  always_comb begin
    lane_sum = '0;
    prod     = '0;
    idx      = 0;
    pidx     = (pass_q >= PW'(NPASS)) ? '0 : pass_q;
    for (int k = 0; k < LANES; k++) begin
      idx      = int'(pidx) * LANES + k;
      prod     = $signed(win_q[16*idx +: 16]) * $signed(w_q[idx]);
      lane_sum = lane_sum + ACC_W'(prod);
    end
  end

  // Bias add, floor rescale and 16-bit saturation of the finished sum
  always_comb begin
    tot = (ACC_W+1)'(acc_q)
        + ((ACC_W+1)'($signed(bias_q)) <<< FRAC);
    shr = tot >>> FRAC;
    hi  = shr[ACC_W:15];
    if (hi != '0 && hi != '1) begin
      sat = shr[ACC_W] ? 16'h8000 : 16'h7FFF;
    end else begin
      sat = shr[15:0];
    end
`ifdef RELU_EN
    if (sat[15]) begin
      sat = 16'h0000;
    end
`endif
  end

  // Next-state, handshakes and weight-port handling
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    w_d         = w_q;
    bias_d      = bias_q;
    acc_d       = acc_q;
    pass_d      = pass_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    wt_err_d    = wt_err_q;
    res_count_d = res_count_q;
    win_ready   = 1'b0;

    unique case (state_q)
      IDLE:    win_ready = 1'b1;
      OUT:     win_ready = res_ready;
      default: win_ready = 1'b0;
    endcase
    accept = win_valid && win_ready;

    if (wt_we && wt_addr <= 5'd27) begin
      if (state_q == IDLE) begin
        if (wt_addr == 5'd27) begin
          bias_d = wt_data;
        end else begin
          w_d[wt_addr] = wt_data;
        end
      end else begin
        wt_err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          win_d   = win_data;
          acc_d   = '0;
          pass_d  = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (pass_q == PW'(NPASS)) begin
          res_data_d  = sat;
          res_valid_d = 1'b1;
          state_d     = OUT;
        end else begin
          acc_d  = acc_q + lane_sum;
          pass_d = pass_q + PW'(1);
        end
      end
      OUT: begin
        if (res_ready) begin
          res_count_d = res_count_q + 16'd1;
          res_valid_d = 1'b0;
          if (accept) begin
            win_d   = win_data;
            acc_d   = '0;
            pass_d  = '0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      win_q       <= '0;
      w_q         <= '{default: '0};
      bias_q      <= '0;
      acc_q       <= '0;
      pass_q      <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      wt_err_q    <= 1'b0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      w_q         <= w_d;
      bias_q      <= bias_d;
      acc_q       <= acc_d;
      pass_q      <= pass_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      wt_err_q    <= wt_err_d;
      res_count_q <= res_count_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign wt_err    = wt_err_q;
  assign res_count = res_count_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_window_mac_engine.sv
// tb_window_mac_engine: directed checks of window_mac_engine.
// Extra instances cover LANES = 1, 3, 27.
module tb_window_mac_engine;

`ifdef RELU_EN
  localparam logic [15:0] NEG_SAT = 16'h0000;
  localparam logic [15:0] NEG_ONE = 16'h0000;
`else
  localparam logic [15:0] NEG_SAT = 16'h8000;
  localparam logic [15:0] NEG_ONE = 16'hFFFF;
`endif

  logic         clk;
  logic         rst;
  logic [431:0] win_data;
  logic         win_valid;
  logic         win_ready;
  logic         wt_we;
  logic [4:0]   wt_addr;
  logic [15:0]  wt_data;
  logic [15:0]  res_data;
  logic         res_valid;
  logic         res_ready;
  logic         busy;
  logic         wt_err;
  logic [15:0]  res_count;

  logic         win_valid_s;
  logic         s_ready [3];
  logic [15:0]  s_data  [3];
  logic         s_valid [3];
  logic         s_busy  [3];
  logic         s_err   [3];
  logic [15:0]  s_cnt   [3];

  int n_cmp;
  int n_bad;
  int exp_cnt;

  window_mac_engine dut (
    .clk       (clk),
    .rst       (rst),
    .win_data  (win_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .wt_we     (wt_we),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .wt_err    (wt_err),
    .res_count (res_count)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int LN = (g == 0) ? 1 : (g == 1) ? 3 : 27;
    window_mac_engine #(.LANES(LN)) u_s (
      .clk       (clk),
      .rst       (rst),
      .win_data  (win_data),
      .win_valid (win_valid_s),
      .win_ready (s_ready[g]),
      .wt_we     (wt_we),
      .wt_addr   (wt_addr),
      .wt_data   (wt_data),
      .res_data  (s_data[g]),
      .res_valid (s_valid[g]),
      .res_ready (1'b1),
      .busy      (s_busy[g]),
      .wt_err    (s_err[g]),
      .res_count (s_cnt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    win_valid   = 1'b0;
    win_valid_s = 1'b0;
    wt_we       = 1'b0;
    res_ready   = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    exp_cnt = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    wt_we   = 1'b1;
    wt_addr = a;
    wt_data = d;
    tick();
    wt_we = 1'b0;
  endtask

  task automatic load(input logic [15:0] w, input logic [15:0] b);
    for (int i = 0; i < 27; i++) wr(5'(i), w);
    wr(5'd27, b);
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 27; i++) win_data[16*i +: 16] = v;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!res_valid && n < 60);
  endtask

  task automatic run_win(input string tag, input logic [15:0] exp);
    int n;
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    wait_res(n);
    check({tag, "_lat"}, n, 4);
    check(tag, res_data, exp);
    tick();
    exp_cnt++;
  endtask

  initial begin
    int n;
    int k;
    int lat [3];
    logic [15:0] sd [3];
    n_cmp   = 0;
    n_bad   = 0;
    wt_addr = '0;
    wt_data = '0;
    win_data = '0;
    do_reset();

    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", wt_err, 0);
    check("rst_cnt", res_count, 0);
    check("rst_ready", win_ready, 1);

    load(16'h0100, 16'h0000);
    fill(16'h0100);
    run_win("dot_ones", 16'h1B00);
    check("cnt_one", res_count, exp_cnt);

    lat = '{0, 0, 0};
    sd  = '{16'h0, 16'h0, 16'h0};
    win_valid_s = 1'b1;
    tick();
    win_valid_s = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        if (s_valid[g] && lat[g] == 0) begin
          lat[g] = c;
          sd[g]  = s_data[g];
        end
      end
    end
    check("lat_l1", lat[0], 28);
    check("lat_l3", lat[1], 10);
    check("lat_l27", lat[2], 2);
    check("dat_l1", sd[0], 16'h1B00);
    check("dat_l3", sd[1], 16'h1B00);
    check("dat_l27", sd[2], 16'h1B00);

    wr(5'd28, 16'h1234);
    check("a28_err", wt_err, 0);
    run_win("a28_dot", 16'h1B00);

    wt_we     = 1'b1;
    wt_addr   = 5'd27;
    wt_data   = 16'h0100;
    win_valid = 1'b1;
    tick();
    wt_we     = 1'b0;
    win_valid = 1'b0;
    wait_res(n);
    check("wr_acc_lat", n, 4);
    check("wr_acc", res_data, 16'h1C00);
    tick();
    exp_cnt++;

    load(16'h0100, 16'hFE00);
    fill(16'h0080);
    run_win("bias_neg", 16'h0B80);

    for (int i = 0; i < 27; i++) wr(5'(i), 16'(i));
    wr(5'd27, 16'h0000);
    for (int i = 0; i < 27; i++)
      win_data[16*i +: 16] = 16'((i + 1) * 256);
    run_win("lanemap", 16'h1998);

    load(16'h0080, 16'h0000);
    fill(16'h0000);
    win_data[15:0] = 16'hFFFF;
    run_win("floor", NEG_ONE);

    load(16'h7FFF, 16'h0000);
    fill(16'h7FFF);
    run_win("sat_pos", 16'h7FFF);

    load(16'h8001, 16'h0000);
    run_win("sat_neg", NEG_SAT);
    check("cnt_mid", res_count, exp_cnt);

    load(16'h0100, 16'h0000);
    fill(16'h0100);
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    wr(5'd3, 16'h0000);
    check("err_set", wt_err, 1);
    wait_res(n);
    check("err_lat", n, 3);
    check("err_dot", res_data, 16'h1B00);
    tick();
    exp_cnt++;
    check("err_hold", wt_err, 1);

    res_ready = 1'b0;
    win_valid = 1'b1;
    tick();
    fill(16'h0200);
    wait_res(n);
    check("hold_lat", n, 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_v", res_valid, 1);
      check("hold_d", res_data, 16'h1B00);
      check("hold_rdy", win_ready, 0);
    end
    check("hold_cnt", res_count, exp_cnt);
    res_ready = 1'b1;
    tick();
    win_valid = 1'b0;
    exp_cnt++;
    check("b2b_cnt", res_count, exp_cnt);
    check("b2b_v", res_valid, 0);
    check("b2b_busy", busy, 1);
    wait_res(n);
    check("b2b_lat", n, 4);
    check("b2b_dot", res_data, 16'h3600);
    tick();
    exp_cnt++;
    check("b2b_cnt2", res_count, exp_cnt);

    fill(16'h0100);
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("mr_valid", res_valid, 0);
    check("mr_data", res_data, 0);
    check("mr_busy", busy, 0);
    check("mr_err", wt_err, 0);
    check("mr_cnt", res_count, 0);
    tick();
    rst = 1'b1;
    tick();
    exp_cnt = 0;
    run_win("mr_zero_w", 16'h0000);
    load(16'h0100, 16'h0000);
    run_win("mr_dot", 16'h1B00);

    n = 0;
    k = 0;
    win_valid = 1'b1;
    while (k < 200 && n < 2000) begin
      tick();
      n++;
      if (res_valid) begin
        k++;
        if (k == 200) win_valid = 1'b0;
      end
    end
    check("bulk_cyc", n, 1000);
    tick();
    exp_cnt += 200;
    check("bulk_cnt", res_count, exp_cnt);
    check("bulk_busy", busy, 0);
    check("bulk_dot", res_data, 16'h1B00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
